// File: rtl/sram_mbist_pkg.sv
// Shared types and March C- element tables for the SRAM MBIST controller.
// Every table is indexed by element number (bit i belongs to element Ei).
package sram_mbist_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  typedef logic [2:0] elem_t;

  localparam elem_t ELEM_LAST = 3'd5;

  // Op count minus one: E0 and E5 have one op, E1..E4 have two.
  localparam logic [5:0] ELEM_LAST_OP = 6'b011110;
  // Op 0 is a write only in E0. Op 1, where present, is always a write.
  localparam logic [5:0] ELEM_OP0_WR  = 6'b000001;
  // Data pattern per op (1 = all-ones, 0 = all-zeros).
  localparam logic [5:0] ELEM_OP0_ONE = 6'b010100;
  localparam logic [5:0] ELEM_OP1_ONE = 6'b001010;
  // Address direction (1 = descending).
  localparam logic [5:0] ELEM_DOWN    = 6'b011000;

  function automatic logic elem_bit(input logic [5:0] tbl, input elem_t e);
    return (e <= ELEM_LAST) ? tbl[e] : 1'b0;
  endfunction

endpackage

// File: rtl/sram_mbist_addr_gen.sv
// Loadable up/down word-address counter; tc_o flags the last address in the
// current direction.
module sram_mbist_addr_gen #(
  parameter int unsigned P_ADDR_WIDTH = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    load_i,
  input  logic [P_ADDR_WIDTH-1:0] load_val_i,
  input  logic                    step_i,
  input  logic                    down_i,
  output logic [P_ADDR_WIDTH-1:0] addr_o,
  output logic                    tc_o
);

  localparam logic [P_ADDR_WIDTH-1:0] AddrOne = P_ADDR_WIDTH'(1);

  logic [P_ADDR_WIDTH-1:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = load_val_i;
    end else if (step_i) begin
      addr_d = down_i ? (addr_q - AddrOne) : (addr_q + AddrOne);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;
  assign tc_o   = down_i ? (addr_q == '0) : (addr_q == '1);

endmodule

// File: rtl/sram_mbist_ctrl.sv
// March C- memory BIST controller: issues one SRAM op per cycle, checks read
// data one cycle later and records the first mismatch.
module sram_mbist_ctrl
  import sram_mbist_pkg::*;
#(
  parameter int unsigned P_ADDR_WIDTH = 8,
  parameter int unsigned P_DATA_WIDTH = 32
) (
  input  logic                    A_CLK,
  input  logic                    A_RST,
  input  logic                    A_START,
  output logic                    A_BUSY,
  output logic                    A_DONE,
  output logic                    A_FAIL,
  output logic [P_ADDR_WIDTH-1:0] A_FAIL_ADDR,
  output logic [2:0]              A_FAIL_ELEM,
  output logic [P_DATA_WIDTH-1:0] A_FAIL_BITS,
  output logic                    A_BIST_EN,
  output logic                    A_BIST_MEN,
  output logic                    A_BIST_WEN,
  output logic                    A_BIST_REN,
  output logic [P_ADDR_WIDTH-1:0] A_BIST_ADDR,
  output logic [P_DATA_WIDTH-1:0] A_BIST_DIN,
  output logic [P_DATA_WIDTH-1:0] A_BIST_BM,
  input  logic [P_DATA_WIDTH-1:0] A_DOUT
);

  state_e state_q, state_d;
  elem_t  elem_q, elem_d;
  logic   op_q, op_d;

  logic                    ag_load, ag_step, ag_tc;
  logic [P_ADDR_WIDTH-1:0] ag_load_val, ag_addr;

  logic                    men_q, wen_q, ren_q;
  logic [P_DATA_WIDTH-1:0] din_q, bm_q;

  logic                    pend_vld_q, pend_one_q;
  logic [P_ADDR_WIDTH-1:0] pend_addr_q;
  elem_t                   pend_elem_q;

  logic                    fail_q, fail_d;
  logic [P_ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
  elem_t                   fail_elem_q, fail_elem_d;
  logic [P_DATA_WIDTH-1:0] fail_bits_q, fail_bits_d;

  logic                    start_ok, cmp_act, mismatch;
  logic                    run_d, wr_d, one_d;
  logic [P_DATA_WIDTH-1:0] diff;

  sram_mbist_addr_gen #(
    .P_ADDR_WIDTH(P_ADDR_WIDTH)
  ) u_addr_gen (
    .clk_i     (A_CLK),
    .rst_i     (A_RST),
    .load_i    (ag_load),
    .load_val_i(ag_load_val),
    .step_i    (ag_step),
    .down_i    (elem_bit(ELEM_DOWN, elem_q)),
    .addr_o    (ag_addr),
    .tc_o      (ag_tc)
  );

  assign start_ok = A_START && (state_q == StIdle || state_q == StDone);
  // Read data lands one cycle after the read; the last E5 read is checked in DRAIN.
  assign cmp_act  = pend_vld_q && (state_q == StRun || state_q == StDrain);
  assign diff     = A_DOUT ^ {P_DATA_WIDTH{pend_one_q}};
  assign mismatch = cmp_act && (diff != '0);

  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    op_d        = op_q;
    ag_load     = 1'b0;
    ag_load_val = '0;
    ag_step     = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (A_START) begin
          state_d = StRun;
          elem_d  = '0;
          op_d    = 1'b0;
          ag_load = 1'b1;
        end
      end
      StRun: begin
        if (op_q != elem_bit(ELEM_LAST_OP, elem_q)) begin
          op_d = 1'b1;
        end else begin
          op_d = 1'b0;
          if (!ag_tc) begin
            ag_step = 1'b1;
          end else if (elem_q == ELEM_LAST) begin
            state_d = StDrain;
            elem_d  = '0;
            ag_load = 1'b1;
          end else begin
            elem_d      = elem_q + 3'd1;
            ag_load     = 1'b1;
            ag_load_val = {P_ADDR_WIDTH{elem_bit(ELEM_DOWN, elem_d)}};
          end
        end
      end
      StDrain: state_d = StDone;
      default: state_d = StIdle;
    endcase
    if (mismatch) begin
      state_d     = StDone;
      ag_step     = 1'b0;
      ag_load     = 1'b1;
      ag_load_val = '0;
    end
  end

  // Command for the next cycle, decoded from next-state and then registered.
  always_comb begin
    run_d = (state_d == StRun);
    wr_d  = op_d | elem_bit(ELEM_OP0_WR, elem_d);
    one_d = op_d ? elem_bit(ELEM_OP1_ONE, elem_d) : elem_bit(ELEM_OP0_ONE, elem_d);
  end

  always_comb begin
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    fail_bits_d = fail_bits_q;
    if (start_ok) begin
      fail_d      = 1'b0;
      fail_addr_d = '0;
      fail_elem_d = '0;
      fail_bits_d = '0;
    end
    if (mismatch) begin
      fail_d      = 1'b1;
      fail_addr_d = pend_addr_q;
      fail_elem_d = pend_elem_q;
      fail_bits_d = diff;
    end
  end

  always_ff @(posedge A_CLK) begin
    if (A_RST) begin
      state_q <= StIdle;
      elem_q  <= '0;
      op_q    <= 1'b0;
      men_q   <= 1'b0;
      wen_q   <= 1'b0;
      ren_q   <= 1'b0;
      din_q   <= '0;
      bm_q    <= '0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      op_q    <= op_d;
      men_q   <= run_d;
      wen_q   <= run_d & wr_d;
      ren_q   <= run_d & ~wr_d;
      din_q   <= {P_DATA_WIDTH{run_d & wr_d & one_d}};
      bm_q    <= {P_DATA_WIDTH{run_d & wr_d}};
    end
  end

  always_ff @(posedge A_CLK) begin
    if (A_RST) begin
      pend_vld_q  <= 1'b0;
      pend_one_q  <= 1'b0;
      pend_addr_q <= '0;
      pend_elem_q <= '0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
      fail_bits_q <= '0;
    end else begin
      // Reads only ever occur as op 0, so the op-0 pattern is the expected data.
      pend_vld_q  <= ren_q;
      pend_one_q  <= elem_bit(ELEM_OP0_ONE, elem_q);
      pend_addr_q <= ag_addr;
      pend_elem_q <= elem_q;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
      fail_bits_q <= fail_bits_d;
    end
  end

  assign A_BUSY      = (state_q == StRun) || (state_q == StDrain);
  assign A_DONE      = (state_q == StDone);
  assign A_FAIL      = fail_q;
  assign A_FAIL_ADDR = fail_addr_q;
  assign A_FAIL_ELEM = fail_elem_q;
  assign A_FAIL_BITS = fail_bits_q;
  assign A_BIST_EN   = A_BUSY;
  assign A_BIST_MEN  = men_q;
  assign A_BIST_WEN  = wen_q;
  assign A_BIST_REN  = ren_q;
  assign A_BIST_ADDR = ag_addr;
  assign A_BIST_DIN  = din_q;
  assign A_BIST_BM   = bm_q;

endmodule

// File: tb/tb_sram_mbist_ctrl.sv
// Directed bench for sram_mbist_ctrl with a behavioural SRAM that can inject
// one stuck-at fault on the read path.
module tb_sram_mbist_ctrl;

  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst, start;
  logic          busy, done, fail, en, men, wen, ren;
  logic [AW-1:0] fail_addr, addr;
  logic [2:0]    fail_elem;
  logic [DW-1:0] fail_bits, din, bm, dout;

  logic [DW-1:0] mem [256];
  logic [AW-1:0] f_addr = '0;
  logic [DW-1:0] f_sa1 = '0, f_sa0 = '0;
  int            wr_cnt = 0, rd_cnt = 0;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_mbist_ctrl #(
    .P_ADDR_WIDTH(AW),
    .P_DATA_WIDTH(DW)
  ) dut (
    .A_CLK      (clk),
    .A_RST      (rst),
    .A_START    (start),
    .A_BUSY     (busy),
    .A_DONE     (done),
    .A_FAIL     (fail),
    .A_FAIL_ADDR(fail_addr),
    .A_FAIL_ELEM(fail_elem),
    .A_FAIL_BITS(fail_bits),
    .A_BIST_EN  (en),
    .A_BIST_MEN (men),
    .A_BIST_WEN (wen),
    .A_BIST_REN (ren),
    .A_BIST_ADDR(addr),
    .A_BIST_DIN (din),
    .A_BIST_BM  (bm),
    .A_DOUT     (dout)
  );

  always @(posedge clk) begin
    if (men && wen) begin
      mem[addr] <= (din & bm) | (mem[addr] & ~bm);
      wr_cnt <= wr_cnt + 1;
    end
    if (men && ren) begin
      dout <= (addr == f_addr) ? ((mem[addr] & ~f_sa0) | f_sa1) : mem[addr];
      rd_cnt <= rd_cnt + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Cycle 0 is the cycle in which START is high.
  task automatic pulse_start();
    start = 1'b1;
    cyc = 0;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int dc);
    while (done !== 1'b1 && cyc < budget) step();
    dc = cyc;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    step();
    checks++;
    if ({busy, done, fail, en, men, wen, ren} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctl: got %b required 0000000", {busy, done, fail, en, men, wen, ren});
    end
    checks++;
    if ({fail_addr, fail_elem} !== '0 || fail_bits !== '0) begin
      errors++;
      $display("FAIL reset_fail_info: got %h/%h/%h required 0", fail_addr, fail_elem, fail_bits);
    end
    checks++;
    if (addr !== '0 || din !== '0 || bm !== '0) begin
      errors++;
      $display("FAIL reset_cmd: got addr %h din %h bm %h required 0", addr, din, bm);
    end
    start = 1'b0;
    step();
    rst = 1'b0;
    step();
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL reset_idle: got busy/done %b required 00", {busy, done});
    end
  endtask

  // Fault-free pass with command trace checks and a START ignored mid-run.
  task automatic test_full_pass();
    int wb, rb;
    wb = wr_cnt;
    rb = rd_cnt;
    pulse_start();
    checks++;
    if ({busy, en, men, wen, ren} !== 5'b11110 || addr !== 8'h00 || din !== 32'h0 ||
        bm !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL cyc1_w0: got %b addr %h din %h bm %h required 11110 00 0 ffffffff",
               {busy, en, men, wen, ren}, addr, din, bm);
    end
    while (cyc < 2562) begin
      start = (cyc == 500);
      step();
      start = 1'b0;
      case (cyc)
        256, 1282: begin
          checks++;
          if ({busy, men, wen, ren} !== 4'b1110 || addr !== 8'hFF ||
              din !== ((cyc == 1282) ? 32'hFFFF_FFFF : 32'h0) || bm !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL cyc%0d_write: got %b addr %h din %h bm %h", cyc,
                     {busy, men, wen, ren}, addr, din, bm);
          end
        end
        257, 769, 1281, 1283, 2560: begin
          checks++;
          if ({busy, men, wen, ren} !== 4'b1101 || din !== '0 || bm !== '0 ||
              addr !== ((cyc == 1281 || cyc == 2560) ? 8'hFF : (cyc == 1283) ? 8'hFE : 8'h00))
          begin
            errors++;
            $display("FAIL cyc%0d_read: got %b addr %h din %h bm %h", cyc,
                     {busy, men, wen, ren}, addr, din, bm);
          end
        end
        2561: begin
          checks++;
          if ({busy, en, men, wen, ren, done} !== 6'b110000) begin
            errors++;
            $display("FAIL drain: got %b required 110000", {busy, en, men, wen, ren, done});
          end
        end
        default: ;
      endcase
    end
    checks++;
    if ({done, fail, busy, en, men} !== 5'b10000) begin
      errors++;
      $display("FAIL pass_done2562: got done/fail/busy/en/men %b required 10000",
               {done, fail, busy, en, men});
    end
    checks++;
    if (wr_cnt - wb !== 1280 || rd_cnt - rb !== 1280) begin
      errors++;
      $display("FAIL pass_counts: got %0d writes %0d reads required 1280 1280",
               wr_cnt - wb, rd_cnt - rb);
    end
    repeat (5) step();
    checks++;
    if ({done, fail, men} !== 3'b100) begin
      errors++;
      $display("FAIL done_hold: got %b required 100", {done, fail, men});
    end
  endtask

  task automatic test_stuck_at_1();
    int dc, base, men_seen;
    f_addr = 8'h3C;
    f_sa1 = 32'h0000_0020;
    f_sa0 = '0;
    pulse_start();
    checks++;
    if ({done, busy} !== 2'b01) begin
      errors++;
      $display("FAIL sa1_restart: got done/busy %b required 01", {done, busy});
    end
    wait_done(3000, dc);
    checks++;
    if (dc !== 379) begin
      errors++;
      $display("FAIL sa1_done_cycle: got %0d required 379", dc);
    end
    checks++;
    if (fail !== 1'b1 || fail_addr !== 8'h3C || fail_elem !== 3'd1 ||
        fail_bits !== 32'h0000_0020) begin
      errors++;
      $display("FAIL sa1_report: got fail %b addr %h elem %0d bits %h required 1 3c 1 00000020",
               fail, fail_addr, fail_elem, fail_bits);
    end
    base = wr_cnt + rd_cnt;
    men_seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (men === 1'b1) men_seen++;
      step();
    end
    checks++;
    if (men_seen != 0 || wr_cnt + rd_cnt != base || done !== 1'b1) begin
      errors++;
      $display("FAIL sa1_quiet: got %0d MEN cycles %0d accesses done %b required 0 0 1",
               men_seen, wr_cnt + rd_cnt - base, done);
    end
  endtask

  task automatic test_stuck_at_0();
    int dc;
    f_addr = 8'hFF;
    f_sa1 = '0;
    f_sa0 = 32'h8000_0000;
    pulse_start();
    checks++;
    if ({done, fail, busy} !== 3'b001 || fail_addr !== '0 || fail_bits !== '0) begin
      errors++;
      $display("FAIL sa0_clear: got done/fail/busy %b addr %h bits %h required 001 0 0",
               {done, fail, busy}, fail_addr, fail_bits);
    end
    wait_done(3000, dc);
    checks++;
    if (dc !== 1281) begin
      errors++;
      $display("FAIL sa0_done_cycle: got %0d required 1281", dc);
    end
    checks++;
    if (fail !== 1'b1 || fail_addr !== 8'hFF || fail_elem !== 3'd2 ||
        fail_bits !== 32'h8000_0000) begin
      errors++;
      $display("FAIL sa0_report: got fail %b addr %h elem %0d bits %h required 1 ff 2 80000000",
               fail, fail_addr, fail_elem, fail_bits);
    end
  endtask

  task automatic test_restart();
    int dc;
    f_sa1 = '0;
    f_sa0 = '0;
    step();
    pulse_start();
    checks++;
    if ({done, fail, busy} !== 3'b001 || fail_elem !== '0) begin
      errors++;
      $display("FAIL restart_clear: got done/fail/busy %b elem %0d required 001 0",
               {done, fail, busy}, fail_elem);
    end
    wait_done(3000, dc);
    checks++;
    if (dc !== 2562 || fail !== 1'b0) begin
      errors++;
      $display("FAIL restart_pass: got done cycle %0d fail %b required 2562 0", dc, fail);
    end
  endtask

  task automatic test_mid_reset();
    int dc, wb, rb;
    pulse_start();
    while (cyc < 1000) step();
    rst = 1'b1;
    step();
    checks++;
    if ({busy, done, fail, en, men, wen, ren} !== 7'b0 || addr !== '0 || din !== '0 ||
        bm !== '0) begin
      errors++;
      $display("FAIL midreset_outs: got %b addr %h din %h bm %h required all 0",
               {busy, done, fail, en, men, wen, ren}, addr, din, bm);
    end
    start = 1'b1;
    step();
    rst = 1'b0;
    start = 1'b0;
    step();
    checks++;
    if ({busy, done, men} !== 3'b000) begin
      errors++;
      $display("FAIL start_with_reset: got busy/done/men %b required 000", {busy, done, men});
    end
    wb = wr_cnt;
    rb = rd_cnt;
    pulse_start();
    wait_done(3000, dc);
    checks++;
    if (dc !== 2562 || fail !== 1'b0 || wr_cnt - wb !== 1280 || rd_cnt - rb !== 1280) begin
      errors++;
      $display("FAIL postreset_pass: got cycle %0d fail %b wr %0d rd %0d required 2562 0 1280 1280",
               dc, fail, wr_cnt - wb, rd_cnt - rb);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    test_reset();
    test_full_pass();
    test_stuck_at_1();
    test_stuck_at_0();
    test_restart();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/sram_mbist_ctrl.md
SRAM_MBIST_CTRL -- requirements
Module: sram_mbist_ctrl

Interface
REQ-001 SHALL have parameter P_ADDR_WIDTH, default 8, giving the SRAM word address width.
REQ-002 SHALL have parameter P_DATA_WIDTH, default 32, giving the SRAM data width.
REQ-003 SHALL have one clock and a synchronous active-high reset.
REQ-004 A_CLK  in  1  sole clock; the SRAM A_BIST_CLK is tied to the same net.
REQ-005 A_RST  in  1  synchronous active-high reset.
REQ-006 A_START  in  1  single-cycle request to run March C-.
REQ-007 A_BUSY  out  1  test in progress.
REQ-008 A_DONE  out  1  test finished; held until the next start or reset.
REQ-009 A_FAIL  out  1  mismatch detected; valid while A_DONE=1.
REQ-010 A_FAIL_ADDR  out  P_ADDR_WIDTH  address of the first mismatch.
REQ-011 A_FAIL_ELEM  out  3  March element index (0-5) of the first mismatch.
REQ-012 A_FAIL_BITS  out  P_DATA_WIDTH  XOR of expected and actual data at the first mismatch.
REQ-013 A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN  out  1 each  SRAM BIST port controls.
REQ-014 A_BIST_ADDR  out  P_ADDR_WIDTH  BIST address.
REQ-015 A_BIST_DIN and A_BIST_BM  out  P_DATA_WIDTH each  BIST write data and bit mask.
REQ-016 A_DOUT  in  P_DATA_WIDTH  SRAM read data.

Function
REQ-017 SHALL run March C- in this order: E0 any-order(w0); E1 up(r0,w1); E2 up(r1,w0); E3 down(r0,w1); E4 down(r1,w0); E5 any-order(r0).
- E0 and E5 SHALL run ascending.
- "0" SHALL be all-zeros data; "1" SHALL be all-ones data.
REQ-018 Each operation SHALL take exactly one cycle with no idle cycles. A full run is 2560 command cycles for depth 256 (1280 writes, 1280 reads).
REQ-019 Command outputs SHALL be registered.
- Write cycle: MEN=1, WEN=1, REN=0, BM=all-ones, DIN=pattern.
- Read cycle: MEN=1, REN=1, WEN=0, BM=0, DIN=0.
REQ-020 For a read issued in cycle n, A_DOUT SHALL be compared at the end of cycle n+1 against the expected value pipelined alongside the command.
REQ-021 FSM states SHALL be IDLE, RUN, DRAIN, DONE.
- IDLE/DONE to RUN: on A_START.
- RUN to DRAIN: after the last E5 read.
- DRAIN to DONE: after 1 cycle.
- Any state to DONE: on the first mismatch.
REQ-022 Timing from A_START sampled high at the end of cycle 0:
- Commands SHALL be issued in cycles 1 to 2560.
- Cycle 2561 SHALL be DRAIN, with MEN=0.
- A_DONE SHALL be 1 from cycle 2562.
REQ-023 A_BUSY SHALL be 1 in RUN and DRAIN. A_BIST_EN SHALL equal A_BUSY.
REQ-024 On a mismatch detected at the end of cycle m:
- A_FAIL_* SHALL capture that read's data.
- The state SHALL go to DONE, with A_DONE=1 and A_FAIL=1 in cycle m+1.
- The command already issued in cycle m is allowed to complete; no command SHALL be issued from cycle m+1.
REQ-025 The address counter SHALL wrap only at element boundaries:
- Up elements run 0 to 2^P_ADDR_WIDTH-1.
- Down elements run max to 0.
- Element and op indices SHALL advance atomically with the address reload.
REQ-026 A_START SHALL be ignored while A_BUSY=1.
REQ-027 A_START in DONE SHALL clear A_DONE, A_FAIL and A_FAIL_* and start a new run the next cycle.
REQ-028 A_START coincident with A_RST SHALL be ignored.
REQ-029 A_BIST_MEN, A_BIST_WEN and A_BIST_REN SHALL be 0 in every cycle outside RUN.

Reset
REQ-030 When A_RST=1 at a clock edge, the next cycle SHALL have all outputs 0 and state IDLE, including a reset that arrives mid-run.
REQ-031 No SRAM access SHALL be issued in the cycle after reset.
REQ-032 Pending compare data SHALL be discarded on reset.

Structure
REQ-033 Package sram_mbist_pkg SHALL hold:
- the FSM state enum;
- the element index type;
- per-element constants: op count, read/write pattern per op, direction;
- the ELEM_LAST constant.
REQ-034 Sub-module sram_mbist_addr_gen SHALL hold the loadable up/down address counter with a terminal-count flag. Everything else stays in sram_mbist_ctrl.

Verification
REQ-035 Fault-free SRAM model, A_START pulse in cycle 0 -> A_DONE=1 in cycle 2562, A_FAIL=0, 1280 writes and 1280 reads observed.
REQ-036 Stuck-at-1 on bit 5 at address 0x3C -> A_FAIL=1, A_FAIL_ADDR=0x3C, A_FAIL_ELEM=1, A_FAIL_BITS=32'h0000_0020, no MEN after the detection cycle.
REQ-037 Stuck-at-0 on bit 31 at address 0xFF -> A_FAIL_ELEM=2, A_FAIL_ADDR=0xFF, A_FAIL_BITS=32'h8000_0000.
REQ-038 Fault-free run, command trace -> cycle 1281 shows REN=1, ADDR=0xFF (E3 start); cycle 1282 shows WEN=1, ADDR=0xFF, DIN=all-ones.
REQ-039 A_RST in cycle 1000 -> cycle 1001 has all outputs 0 and EN/MEN=0; a later A_START completes a full pass.
REQ-040 A_START pulse in cycle 500 -> no effect. A_START after a failed run -> A_FAIL/A_DONE cleared next cycle, and the fresh run reports a pass on a fault-free model.
